mipi_tx_raw_packer: RTL and testbench

- Transmit-side counterpart of the CSI-2 RAW receive depacker: packs groups of 4 MSB-aligned 16-bit pixels into the CSI-2 RAW10/RAW12/RAW14 byte stream.
- Output is 32-bit words for the 4-lane packet builder; byte 0 of the payload is on data_o[7:0] (lane 0).
- Sits between the pixel source (test pattern or frame buffer) and the CSI-2 TX packet/header generator.
- Uses ready/valid backpressure on the pixel side because packed output takes 5, 6 or 7 bytes per group.

---
 rtl/mipi_csi_pkg.sv | 32 +++
 rtl/mipi_tx_raw_group_pack.sv | 59 +++++
 rtl/mipi_tx_raw_packer.sv | 165 ++++++++++++++++
 tb/tb_mipi_tx_raw_packer.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mipi_csi_pkg.sv
// Shared CSI-2 RAW packing definitions.
// Holds the RAW data-type codes, bytes-per-group counts for each RAW width,
// the packer state encoding and a helper that recognises supported types.
package mipi_csi_pkg;

  localparam logic [5:0] MIPI_CSI_PACKET_10bRAW = 6'h2B;
  localparam logic [5:0] MIPI_CSI_PACKET_12bRAW = 6'h2C;
  localparam logic [5:0] MIPI_CSI_PACKET_14bRAW = 6'h2D;

  // The packer port carries only the low three bits of the data type.
  localparam logic [2:0] RAW10_TYPE = MIPI_CSI_PACKET_10bRAW[2:0];
  localparam logic [2:0] RAW12_TYPE = MIPI_CSI_PACKET_12bRAW[2:0];
  localparam logic [2:0] RAW14_TYPE = MIPI_CSI_PACKET_14bRAW[2:0];

  // Bytes produced per group of four pixels.
  localparam logic [2:0] RAW10_GROUP_BYTES = 3'd5;
  localparam logic [2:0] RAW12_GROUP_BYTES = 3'd6;
  localparam logic [2:0] RAW14_GROUP_BYTES = 3'd7;
  localparam int unsigned GROUP_BYTES_MAX  = 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } pack_state_e;

  function automatic logic is_raw_supported(input logic [2:0] raw_type);
    return (raw_type == RAW10_TYPE) || (raw_type == RAW12_TYPE) ||
           (raw_type == RAW14_TYPE);
  endfunction

endpackage

// File: rtl/mipi_tx_raw_group_pack.sv
// Combinational packer for one group of four MSB-aligned 16-bit pixels.
// Ports:
//   type_i    - RAW data type (low 3 bits of the CSI-2 data type)
//   pixels_i  - {P0,P1,P2,P3}, P0 in [63:48], each pixel MSB-aligned
//   bytes_o   - packed bytes, byte 0 in [7:0]; unused high bytes are zero
//   nbytes_o  - number of valid bytes (5/6/7), 0 for an unsupported type
module mipi_tx_raw_group_pack
  import mipi_csi_pkg::*;
(
  input  logic [2:0]  type_i,
  input  logic [63:0] pixels_i,
  output logic [55:0] bytes_o,
  output logic [2:0]  nbytes_o
);

  logic [15:0] p0, p1, p2, p3;
  logic        unused_pad_bits;

  assign p0 = pixels_i[63:48];
  assign p1 = pixels_i[47:32];
  assign p2 = pixels_i[31:16];
  assign p3 = pixels_i[15:0];

  // Bits [1:0] of every slot are padding below the widest (14-bit) pixel.
  assign unused_pad_bits = ^{p0[1:0], p1[1:0], p2[1:0], p3[1:0]};

  // A pixel of width W occupies slot bits [15:16-W], so pixel bit [W-1:W-8]
  // is always slot bits [15:8]; the remaining LSBs sit directly below.
  always_comb begin
    bytes_o  = '0;
    nbytes_o = '0;
    case (type_i)
      RAW10_TYPE: begin
        bytes_o  = {8'h00, 8'h00,
                    {p3[7:6], p2[7:6], p1[7:6], p0[7:6]},
                    p3[15:8], p2[15:8], p1[15:8], p0[15:8]};
        nbytes_o = RAW10_GROUP_BYTES;
      end
      RAW12_TYPE: begin
        bytes_o  = {8'h00,
                    {p3[7:4], p2[7:4]}, p3[15:8], p2[15:8],
                    {p1[7:4], p0[7:4]}, p1[15:8], p0[15:8]};
        nbytes_o = RAW12_GROUP_BYTES;
      end
      RAW14_TYPE: begin
        bytes_o  = {{p3[7:2], p2[7:6]},
                    {p2[5:2], p1[7:4]},
                    {p1[3:2], p0[7:2]},
                    p3[15:8], p2[15:8], p1[15:8], p0[15:8]};
        nbytes_o = RAW14_GROUP_BYTES;
      end
      default: begin
        bytes_o  = '0;
        nbytes_o = '0;
      end
    endcase
  end

endmodule

// File: rtl/mipi_tx_raw_packer.sv
// CSI-2 RAW10/12/14 transmit packer.
// Accepts groups of four MSB-aligned pixels under ready/valid and emits a
// registered 32-bit payload word stream (byte 0 in [7:0]) with a line-end
// marker and a valid-byte count on the final word.
// Ports:
//   clk_i, reset_n_i       - clock, synchronous active-low reset
//   packet_type_i          - RAW type, sampled only in IDLE
//   pixel_valid_i/_last_i  - group valid / final group of the line
//   pixels_i               - {P0,P1,P2,P3}
//   pixel_ready_o          - group accepted when valid & ready
//   data_valid_o, data_o   - payload word strobe and data
//   data_last_o            - final word of the line
//   last_bytes_o           - valid bytes in the final word (4 otherwise)
module mipi_tx_raw_packer
  import mipi_csi_pkg::*;
#(
  parameter int unsigned BUF_BYTES = 16
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic [2:0]  packet_type_i,
  input  logic        pixel_valid_i,
  input  logic        pixel_last_i,
  input  logic [63:0] pixels_i,
  output logic        pixel_ready_o,
  output logic        data_valid_o,
  output logic [31:0] data_o,
  output logic        data_last_o,
  output logic [2:0]  last_bytes_o
);

  localparam int unsigned BUF_W  = BUF_BYTES * 8;
  localparam int unsigned FILL_W = $clog2(BUF_BYTES + 1);
  localparam logic [FILL_W-1:0] FILL_WORD      = FILL_W'(4);
  localparam logic [FILL_W-1:0] FILL_READY_MAX = FILL_W'(BUF_BYTES - 8);

  pack_state_e       state_q, state_d;
  logic [2:0]        type_q, type_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [BUF_W-1:0]  buf_q, buf_d;
  logic              data_valid_q, data_valid_d;
  logic [31:0]       data_q, data_d;
  logic              data_last_q, data_last_d;
  logic [2:0]        last_bytes_q, last_bytes_d;

  logic [55:0]       grp_bytes;
  logic [2:0]        grp_nbytes;
  logic [BUF_W-1:0]  grp_ext;
  logic              type_supported;
  logic              pixel_ready;
  logic              accept;
  logic [FILL_W-1:0] rem_c;
  logic [BUF_W-1:0]  remain_c;

  mipi_tx_raw_group_pack u_group_pack (
    .type_i   (type_q),
    .pixels_i (pixels_i),
    .bytes_o  (grp_bytes),
    .nbytes_o (grp_nbytes)
  );

  assign grp_ext        = {{(BUF_W - 56){1'b0}}, grp_bytes};
  assign type_supported = is_raw_supported(type_q);

  // Ready leaves room for a worst-case 7-byte group after a word is emitted.
  // An unsupported type never fills the buffer, so groups are simply sunk.
  always_comb begin
    pixel_ready = (state_q == ST_RUN) &&
                  (!type_supported || (fill_q <= FILL_READY_MAX));
  end

  assign pixel_ready_o = pixel_ready;
  assign accept        = pixel_valid_i & pixel_ready;

  // Buffer holds bytes oldest-first from bit 0; bytes above fill are kept
  // zero so a short final word naturally has zero high bytes.
  always_comb begin
    state_d      = state_q;
    type_d       = type_q;
    fill_d       = fill_q;
    buf_d        = buf_q;
    data_valid_d = 1'b0;
    data_d       = data_q;
    data_last_d  = 1'b0;
    last_bytes_d = 3'd4;
    rem_c        = fill_q;
    remain_c     = buf_q;

    case (state_q)
      ST_IDLE: begin
        type_d  = packet_type_i;
        fill_d  = '0;
        buf_d   = '0;
        state_d = ST_RUN;
      end

      ST_RUN, ST_DRAIN: begin
        if (fill_q >= FILL_WORD) begin
          data_valid_d = 1'b1;
          data_d       = buf_q[31:0];
          remain_c     = buf_q >> 32;
          rem_c        = fill_q - FILL_WORD;
          if ((state_q == ST_DRAIN) && (fill_q == FILL_WORD)) begin
            data_last_d = 1'b1;
            state_d     = ST_IDLE;
          end
        end else if (state_q == ST_DRAIN) begin
          if (fill_q != '0) begin
            data_valid_d = 1'b1;
            data_d       = buf_q[31:0];
            data_last_d  = 1'b1;
            last_bytes_d = fill_q[2:0];
          end
          remain_c = '0;
          rem_c    = '0;
          state_d  = ST_IDLE;
        end

        // New group lands directly behind whatever survived this cycle's emit.
        if (accept) begin
          if (type_supported) begin
            remain_c = remain_c | (grp_ext << {rem_c, 3'b000});
            rem_c    = rem_c + FILL_W'(grp_nbytes);
          end
          if (pixel_last_i) begin
            state_d = type_supported ? ST_DRAIN : ST_IDLE;
          end
        end

        fill_d = rem_c;
        buf_d  = remain_c;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q      <= ST_IDLE;
      type_q       <= '0;
      fill_q       <= '0;
      buf_q        <= '0;
      data_valid_q <= 1'b0;
      data_q       <= '0;
      data_last_q  <= 1'b0;
      last_bytes_q <= 3'd4;
    end else begin
      state_q      <= state_d;
      type_q       <= type_d;
      fill_q       <= fill_d;
      buf_q        <= buf_d;
      data_valid_q <= data_valid_d;
      data_q       <= data_d;
      data_last_q  <= data_last_d;
      last_bytes_q <= last_bytes_d;
    end
  end

  assign data_valid_o = data_valid_q;
  assign data_o       = data_q;
  assign data_last_o  = data_last_q;
  assign last_bytes_o = last_bytes_q;

endmodule

// File: tb/tb_mipi_tx_raw_packer.sv
// Self-checking bench for mipi_tx_raw_packer: directed test-plan lines plus
// randomized lines scored against a byte-stream reference model.
module tb_mipi_tx_raw_packer;

  logic        clk_i = 1'b0;
  logic        reset_n_i;
  logic [2:0]  packet_type_i;
  logic        pixel_valid_i;
  logic        pixel_last_i;
  logic [63:0] pixels_i;
  logic        pixel_ready_o;
  logic        data_valid_o;
  logic [31:0] data_o;
  logic        data_last_o;
  logic [2:0]  last_bytes_o;

  always #5 clk_i = ~clk_i;

  mipi_tx_raw_packer #(.BUF_BYTES(16)) u_dut (
    .clk_i         (clk_i),
    .reset_n_i     (reset_n_i),
    .packet_type_i (packet_type_i),
    .pixel_valid_i (pixel_valid_i),
    .pixel_last_i  (pixel_last_i),
    .pixels_i      (pixels_i),
    .pixel_ready_o (pixel_ready_o),
    .data_valid_o  (data_valid_o),
    .data_o        (data_o),
    .data_last_o   (data_last_o),
    .last_bytes_o  (last_bytes_o)
  );

  int unsigned total = 0;
  int unsigned bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Reference model: expected payload bytes in stream order.
  logic [7:0]  exp_q[$];
  logic [31:0] wlog[$];
  logic [2:0]  line_t;
  logic        line_end  = 1'b0;
  logic        line_done = 1'b0;
  int          cyc = 0;
  int          n_acc, first_acc, last_acc;
  int          n_words, first_w, last_w;
  logic [2:0]  last_lb;

  function automatic void model_group(input logic [2:0] t, input logic [63:0] px);
    int unsigned v[4];
    int unsigned lsb;
    logic [15:0] p;
    int          w;
    w = (t == 3'd3) ? 10 : (t == 3'd4) ? 12 : 14;
    for (int i = 0; i < 4; i++) begin
      p    = px[63-16*i -: 16];
      v[i] = int'(p) >> (16 - w);
    end
    case (t)
      3'd3: begin
        lsb = 0;
        for (int i = 0; i < 4; i++) begin
          exp_q.push_back(8'(v[i] >> 2));
          lsb |= (v[i] & 3) << (2 * i);
        end
        exp_q.push_back(8'(lsb));
      end
      3'd4: begin
        for (int k = 0; k < 2; k++) begin
          exp_q.push_back(8'(v[2*k] >> 4));
          exp_q.push_back(8'(v[2*k+1] >> 4));
          exp_q.push_back(8'((v[2*k] & 15) | ((v[2*k+1] & 15) << 4)));
        end
      end
      3'd5: begin
        lsb = 0;
        for (int i = 0; i < 4; i++) begin
          exp_q.push_back(8'(v[i] >> 6));
          lsb |= (v[i] & 63) << (6 * i);
        end
        for (int b = 0; b < 3; b++) exp_q.push_back(8'(lsb >> (8 * b)));
      end
      default: ;
    endcase
  endfunction

  // Monitor: outputs and acceptances are sampled on the falling edge.
  always @(negedge clk_i) begin : mon
    int          nb;
    logic [31:0] ew;
    logic        el;
    cyc++;
    if (!reset_n_i) begin
      exp_q.delete();
      line_end = 1'b0;
    end else begin
      if (data_valid_o) begin
        if (n_words == 0) first_w = cyc;
        last_w = cyc;
        n_words++;
        wlog.push_back(data_o);
        if (data_last_o) last_lb = last_bytes_o;
        if (exp_q.size() == 0) begin
          chk("spurious_word", 32'(data_valid_o), 32'd0);
        end else begin
          nb = (exp_q.size() > 4) ? 4 : exp_q.size();
          ew = '0;
          for (int i = 0; i < nb; i++) ew |= 32'(exp_q.pop_front()) << (8 * i);
          el = line_end && (exp_q.size() == 0);
          chk("word_data", data_o, ew);
          chk("word_last", 32'(data_last_o), 32'(el));
          chk("word_bytes", 32'(last_bytes_o), el ? 32'(nb) : 32'd4);
          if (el) begin
            line_end  = 1'b0;
            line_done = 1'b1;
          end
        end
      end
      if (pixel_valid_i && pixel_ready_o) begin
        if (n_acc == 0) first_acc = cyc;
        last_acc = cyc;
        n_acc++;
        model_group(line_t, pixels_i);
        if (pixel_last_i && (line_t >= 3'd3) && (line_t <= 3'd5)) line_end = 1'b1;
      end
    end
  end

  task automatic clear_stats();
    n_acc = 0; n_words = 0; first_acc = 0; last_acc = 0;
    first_w = 0; last_w = 0; last_lb = 3'd0;
    line_done = 1'b0;
    wlog.delete();
  endtask

  task automatic send_group(input logic [63:0] px, input logic last);
    logic got;
    pixel_valid_i = 1'b1;
    pixels_i      = px;
    pixel_last_i  = last;
    got = 1'b0;
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge clk_i);
      got = pixel_ready_o;
      @(posedge clk_i);
      #1;
    end
    if (!got) chk("accept_timeout", 32'(got), 32'd1);
    pixel_valid_i = 1'b0;
    pixel_last_i  = 1'b0;
  endtask

  // mode 0: random pixels; mode 1: incrementing 14-bit pixel values.
  task automatic send_line(input int t, input int n, input int gap_pct,
                           input int next_t, input int mode);
    logic [63:0] px;
    int unsigned v;
    line_t = 3'(t);
    clear_stats();
    for (int g = 0; g < n; g++) begin
      if (gap_pct > 0 && $urandom_range(99) < gap_pct)
        repeat ($urandom_range(3, 1)) begin @(posedge clk_i); #1; end
      if (mode == 0) begin
        px = {$urandom, $urandom};
      end else begin
        for (int j = 0; j < 4; j++) begin
          v = (32'(g) * 4 + 32'(j)) * 37 + 1;
          px[63-16*j -: 16] = 16'((v & 32'h3FFF) << 2);
        end
      end
      send_group(px, g == n - 1);
    end
    packet_type_i = 3'(next_t);
  endtask

  task automatic wait_line_done(input int budget);
    for (int k = 0; k < budget && !line_done; k++) @(posedge clk_i);
    #1;
    chk("line_done", 32'(line_done), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int nt, t, n, ew;
    pixel_valid_i = 1'b0;
    pixel_last_i  = 1'b0;
    pixels_i      = '0;
    packet_type_i = 3'd3;
    reset_n_i     = 1'b0;
    line_t        = 3'd3;
    clear_stats();
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_valid", 32'(data_valid_o), 32'd0);
    chk("rst_data", data_o, 32'd0);
    chk("rst_last", 32'(data_last_o), 32'd0);
    chk("rst_lbytes", 32'(last_bytes_o), 32'd4);
    chk("rst_ready", 32'(pixel_ready_o), 32'd0);
    reset_n_i = 1'b1;

    // RAW10 single group
    line_t = 3'd3;
    clear_stats();
    send_group(64'hFFC0_0000_AA80_5540, 1'b1);
    packet_type_i = 3'd4;
    wait_line_done(50);
    chk("r10_words", 32'(n_words), 32'd2);
    chk("r10_w0", wlog.size() > 0 ? wlog[0] : 32'hDEAD_BEEF, 32'h55AA00FF);
    chk("r10_w1", wlog.size() > 1 ? wlog[1] : 32'hDEAD_BEEF, 32'h00000063);
    chk("r10_lbytes", 32'(last_lb), 32'd1);

    // RAW12 single group
    line_t = 3'd4;
    clear_stats();
    send_group(64'hABC0_1230_0000_0000, 1'b1);
    packet_type_i = 3'd3;
    wait_line_done(50);
    chk("r12_words", 32'(n_words), 32'd2);
    chk("r12_w0", wlog.size() > 0 ? wlog[0] : 32'hDEAD_BEEF, 32'h003C12AB);
    chk("r12_w1", wlog.size() > 1 ? wlog[1] : 32'hDEAD_BEEF, 32'h00000000);
    chk("r12_lbytes", 32'(last_lb), 32'd2);

    // RAW10 16 groups, valid held high: 4 accepts per 5 cycles
    send_line(3, 16, 0, 5, 0);
    wait_line_done(100);
    chk("r10s_words", 32'(n_words), 32'd20);
    chk("r10s_nogap", 32'(last_w - first_w + 1), 32'd20);
    chk("r10s_stalls", 32'((last_acc - first_acc + 1) - n_acc), 32'd3);
    chk("r10s_lbytes", 32'(last_lb), 32'd4);

    // RAW14 8 incrementing groups: 4 accepts per 7 cycles
    send_line(5, 8, 0, 4, 1);
    wait_line_done(100);
    chk("r14_words", 32'(n_words), 32'd14);
    chk("r14_nogap", 32'(last_w - first_w + 1), 32'd14);
    chk("r14_stalls", 32'((last_acc - first_acc + 1) - n_acc), 32'd5);
    chk("r14_lbytes", 32'(last_lb), 32'd4);

    // Reset mid-line with 6 bytes buffered (RAW12 group just accepted)
    line_t = 3'd4;
    clear_stats();
    send_group({$urandom, $urandom}, 1'b0);
    reset_n_i     = 1'b0;
    packet_type_i = 3'd3;
    @(posedge clk_i);
    #1;
    reset_n_i = 1'b1;
    @(negedge clk_i);
    chk("mrst_valid", 32'(data_valid_o), 32'd0);
    chk("mrst_ready", 32'(pixel_ready_o), 32'd0);
    chk("mrst_no_out", 32'(n_words), 32'd0);
    @(posedge clk_i);
    #1;
    line_t = 3'd3;
    clear_stats();
    send_group(64'hFFC0_0000_AA80_5540, 1'b1);
    packet_type_i = 3'd1;
    wait_line_done(50);
    chk("mrst_w0", wlog.size() > 0 ? wlog[0] : 32'hDEAD_BEEF, 32'h55AA00FF);
    chk("mrst_words", 32'(n_words), 32'd2);

    // Unsupported type: groups sunk, last returns to IDLE, no output
    line_t = 3'd1;
    clear_stats();
    for (int g = 0; g < 3; g++) send_group({$urandom, $urandom}, g == 2);
    packet_type_i = 3'd3;
    @(negedge clk_i);
    chk("unsup_idle", 32'(pixel_ready_o), 32'd0);
    repeat (6) @(posedge clk_i);
    #1;
    chk("unsup_no_out", 32'(n_words), 32'd0);
    chk("unsup_acc", 32'(n_acc), 32'd3);

    // RAW10 line after the unsupported one, then randomized lines
    nt = 3 + $urandom_range(2);
    send_line(3, 4, 20, nt, 0);
    wait_line_done(100);
    chk("post_unsup_words", 32'(n_words), 32'd5);

    for (int l = 0; l < 12; l++) begin
      t  = nt;
      nt = 3 + $urandom_range(2);
      n  = 1 + $urandom_range(9);
      send_line(t, n, 30, nt, 0);
      wait_line_done(300);
      ew = (n * (t + 2) + 3) / 4;
      chk("rand_words", 32'(n_words), 32'(ew));
      chk("rand_lbytes", 32'(last_lb), 32'(n * (t + 2) - 4 * (ew - 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
